// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the serializer slice.
// Holds the default symbol width, the four TMDS control symbols, the
// clock-lane pattern and a ceiling-log2 helper used for counter sizing.
package tmds_pkg;

    localparam int SYM_W_DEF = 10;

    // Control-period symbols; CTL00 is the idle symbol sent on underflow.
    localparam logic [9:0] CTL00 = 10'b1101010100;
    localparam logic [9:0] CTL01 = 10'b0010101011;
    localparam logic [9:0] CTL10 = 10'b0101010100;
    localparam logic [9:0] CTL11 = 10'b1010101011;

    // Five ones then five zeros: one TMDS clock period per symbol.
    localparam logic [9:0] CLK_SYM_DEF = 10'b1111100000;

    // Ceiling log2, never less than 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tmds_serializer_mc_if.sv
// Symbol handshake bundle between the TMDS encoders and the serializer.
//   sym_data  : NUM_CH symbols, lane i at [i*SYM_W +: SYM_W]
//   sym_valid : sym_data is valid
//   sym_ready : serializer can accept this cycle
// master = encoder side, slave = serializer side.
interface tmds_serializer_mc_if
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int SYM_W  = SYM_W_DEF
);
    logic [NUM_CH*SYM_W-1:0] sym_data;
    logic                    sym_valid;
    logic                    sym_ready;

    modport master (output sym_data, output sym_valid, input sym_ready);
    modport slave  (input sym_data, input sym_valid, output sym_ready);
endinterface

// File: rtl/tmds_lane_shift.sv
// One serializer lane: a symbol shift register, the SDR/DDR output
// phase mux and the optional output inversion.
// Ports:
//   serclk, rst  : bit clock, async active-high reset
//   i_en         : lane enabled; when low the register is cleared
//   i_load       : load i_load_val at this edge (symbol boundary)
//   i_load_val   : symbol to load, LSB leaves first
//   o_ser        : serial output
module tmds_lane_shift
    import tmds_pkg::*;
#(
    parameter int   SYM_W = SYM_W_DEF,
    parameter int   BPC   = 2,
    parameter logic INV   = 1'b0
) (
    input  logic             serclk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [SYM_W-1:0] i_load_val,
    output logic             o_ser
);

    logic [SYM_W-1:0] r_sr;
    logic             w_raw;

    // Shift register: load at boundaries, otherwise shift out BPC bits.
    always_ff @(posedge serclk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (!i_en) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_load_val;
        end else begin
            r_sr <= r_sr >> BPC;
        end
    end

    // In DDR the high half of serclk carries bit 0 and the low half bit 1,
    // so the pad sees both bits of the pair within one serclk period.
    generate
        if (BPC == 2) begin : g_ddr
            assign w_raw = serclk ? r_sr[0] : r_sr[1];
        end else begin : g_sdr
            assign w_raw = r_sr[0];
        end
    endgenerate

    assign o_ser = w_raw ^ INV;

endmodule

// File: rtl/tmds_serializer_mc.sv
// Multi-lane TMDS serializer: NUM_CH data lanes plus a clock lane, with a
// one-entry holding buffer, idle-symbol substitution on underflow,
// per-lane inversion and an enable gate.
// Ports:
//   serclk, rst       : bit clock (both edges used in DDR), async reset
//   i_en              : serializer enable
//   i_underflow_clr   : clears the sticky underflow flag
//   bus (slave)       : sym_data / sym_valid / sym_ready handshake
//   o_load_strobe     : pulse, shift registers loaded at the last edge
//   o_underflow       : sticky, idle symbol was substituted
//   o_ser_data        : serial data lanes
//   o_ser_clk         : serial TMDS clock lane
module tmds_serializer_mc
    import tmds_pkg::*;
#(
    parameter int                NUM_CH   = 3,
    parameter int                SYM_W    = SYM_W_DEF,
    parameter int                DDR      = 1,
    parameter logic [SYM_W-1:0]  CLK_SYM  = CLK_SYM_DEF,
    parameter logic [SYM_W-1:0]  IDLE_SYM = CTL00,
    parameter logic [NUM_CH:0]   LANE_INV = '0
) (
    input  logic                 serclk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_underflow_clr,
    tmds_serializer_mc_if.slave  bus,
    output logic                 o_load_strobe,
    output logic                 o_underflow,
    output logic [NUM_CH-1:0]    o_ser_data,
    output logic                 o_ser_clk
);

    localparam int BPC   = (DDR != 0) ? 2 : 1;
    localparam int BEATS = SYM_W / BPC;
    localparam int CNT_W = clog2(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic                    r_hold_full;
    logic [NUM_CH*SYM_W-1:0] r_hold;
    logic                    r_load_strobe;
    logic                    r_underflow;

    logic                    w_load_now;
    logic                    w_ready;
    logic                    w_accept;
    logic [SYM_W-1:0]        w_load_val [NUM_CH+1];
    logic [NUM_CH:0]         w_ser;

    assign w_load_now    = i_en && (r_cnt == CNT_LAST);
    // At a boundary the held word moves to the shift registers, so the
    // buffer can take a new word in the same cycle even when full.
    assign w_ready       = i_en && (!r_hold_full || w_load_now);
    assign w_accept      = bus.sym_valid && w_ready;
    assign bus.sym_ready = w_ready;

    // Beat counter, holding buffer and status flags.
    always_ff @(posedge serclk or posedge rst) begin
        if (rst) begin
            r_cnt         <= CNT_LAST;
            r_hold_full   <= 1'b0;
            r_hold        <= '0;
            r_load_strobe <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_load_strobe <= w_load_now;

            // Parking the counter at the last beat makes the first edge
            // after enable a load edge.
            if (!i_en) begin
                r_cnt <= CNT_LAST;
            end else if (w_load_now) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_accept) begin
                r_hold      <= bus.sym_data;
                r_hold_full <= 1'b1;
            end else if (w_load_now) begin
                r_hold_full <= 1'b0;
            end else begin
                r_hold_full <= r_hold_full;
            end

            // Setting has priority over a coincident clear.
            if (w_load_now && !r_hold_full) begin
                r_underflow <= 1'b1;
            end else if (i_underflow_clr) begin
                r_underflow <= 1'b0;
            end else begin
                r_underflow <= r_underflow;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi <= NUM_CH; gi = gi + 1) begin : g_lane
            if (gi < NUM_CH) begin : g_data
                assign w_load_val[gi] = r_hold_full ? r_hold[gi*SYM_W +: SYM_W] : IDLE_SYM;
            end else begin : g_clk
                assign w_load_val[gi] = CLK_SYM;
            end

            tmds_lane_shift #(
                .SYM_W (SYM_W),
                .BPC   (BPC),
                .INV   (LANE_INV[gi])
            ) u_lane (
                .serclk     (serclk),
                .rst        (rst),
                .i_en       (i_en),
                .i_load     (w_load_now),
                .i_load_val (w_load_val[gi]),
                .o_ser      (w_ser[gi])
            );
        end
    endgenerate

    assign o_ser_data    = w_ser[NUM_CH-1:0];
    assign o_ser_clk     = w_ser[NUM_CH];
    assign o_load_strobe = r_load_strobe;
    assign o_underflow   = r_underflow;

endmodule
